// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester handshake and shared-transmitter signals for uart_tx_arbiter.
// master is the arbiter side; slave is the requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [IdW-1:0]       grant_id;
  logic                 active;
  logic                 done;
  logic                 err_noack;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, active, done, err_noack
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, active, done, err_noack
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters,
// with launch pulse, busy handshake, ack timeout and completion pulse.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] last_grant_q, last_grant_d;
  logic [IdW-1:0] grant_q, grant_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     cnt_q, cnt_d;

  logic           win_found;
  logic [IdW-1:0] win_idx;
  logic [IdW-1:0] cand;
  logic           grant_ok;
  logic           tx_start_c, done_c, err_c;

  // Search upward from last_grant+1 with wrap; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant_ok = rst_n && (state_q == StIdle) && !bus.tx_busy && win_found;

  always_comb begin
    bus.req_ready = '0;
    if (grant_ok) begin
      bus.req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    tx_start_c   = 1'b0;
    done_c       = 1'b0;
    err_c        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_ok) begin
          data_d       = bus.req_data[{win_idx, 3'b000} +: 8];
          grant_d      = win_idx;
          last_grant_d = win_idx;
          state_d      = StLaunch;
        end
      end
      StLaunch: begin
        tx_start_c = 1'b1;
        cnt_d      = '0;
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == 8'(ACK_TIMEOUT)) begin
          err_c   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          done_c  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= IdW'(NUM_REQ - 1);
      grant_q      <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end

  // Pulses are masked while reset is held so an aborted sequence emits nothing.
  assign bus.tx_start  = tx_start_c & rst_n;
  assign bus.done      = done_c & rst_n;
  assign bus.err_noack = err_c & rst_n;
  assign bus.tx_data   = data_q;
  assign bus.grant_id  = grant_q;
  assign bus.active    = (state_q != StIdle);

endmodule
